// File: rtl/character_pkg.sv
// Shared constants, sprite bitmap and FSM encoding for the character
// draw/erase blocks. Both blocks import this so geometry and background
// colour can never drift apart.
package character_pkg;

   localparam int CHAR_W = 9;
   localparam int CHAR_H = 5;

   localparam logic [1:0] POS0 = 2'd0;
   localparam logic [1:0] POS1 = 2'd1;
   localparam logic [1:0] POS2 = 2'd2;
   localparam logic [1:0] POS3 = 2'd3;

   localparam logic [7:0] POS_X0 = 8'd6;
   localparam logic [7:0] POS_X1 = 8'd24;
   localparam logic [7:0] POS_X2 = 8'd78;
   localparam logic [7:0] POS_X3 = 8'd132;

   localparam logic [6:0] BASE_Y   = 7'd102;
   localparam logic [2:0] FG_COLOR = 3'b111;
   localparam logic [2:0] BG_COLOR = 3'b011;

   // Last column / row of the scan, sized to the counters.
   localparam logic [3:0] LAST_COL = 4'(CHAR_W - 1);
   localparam logic [2:0] LAST_ROW = 3'(CHAR_H - 1);

   // SPRITE[row][8-col]: column 0 is the MSB of each row.
   localparam logic [CHAR_H-1:0][CHAR_W-1:0] SPRITE = {
      9'b010000010,   // row 4
      9'b001111100,   // row 3
      9'b111111111,   // row 2
      9'b001111100,   // row 1
      9'b000111000    // row 0
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Left edge of the sprite for a lane position.
   function automatic logic [7:0] pos_x(input logic [1:0] pos);
      logic [7:0] x;
      case (pos)
         POS0:    x = POS_X0;
         POS1:    x = POS_X1;
         POS2:    x = POS_X2;
         default: x = POS_X3;
      endcase
      return x;
   endfunction

endpackage

// File: rtl/character_sprite_rom.sv
// Combinational lookup of one sprite pixel; addresses outside the 9x5
// bitmap read as 0 (background).
module character_sprite_rom
   import character_pkg::*;
(
   input  logic [2:0] row_i,
   input  logic [3:0] col_i,
   output logic       pix_o
);

   logic [CHAR_W-1:0] row_bits;

   // Select the row, then the column bit (column 0 is the MSB).
   always_comb begin
      row_bits = '0;
      case (row_i)
         3'd0:    row_bits = SPRITE[0];
         3'd1:    row_bits = SPRITE[1];
         3'd2:    row_bits = SPRITE[2];
         3'd3:    row_bits = SPRITE[3];
         3'd4:    row_bits = SPRITE[4];
         default: row_bits = '0;
      endcase
      pix_o = 1'b0;
      if (col_i <= LAST_COL) begin
         pix_o = row_bits[LAST_COL - col_i];
      end
   end

endmodule

// File: rtl/draw_character.sv
// Streams the 9x5 player sprite at one of four lane positions into the
// VGA write port, one pixel per clock, with a Start/DoneDrawing handshake.
module draw_character
   import character_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic [3:0] CurrState,
   output logic [7:0] XOut,
   output logic [6:0] YOut,
   output logic [2:0] Color,
   output logic       Plot,
   output logic       Busy,
   output logic       DoneDrawing
);

   state_e     state_q;
   logic [7:0] base_q, base_d;
   logic [3:0] col_q, col_d;
   logic [2:0] row_q, row_d;
   logic       pix;

   // Address of the pixel to present next: (0,0) when launching from IDLE,
   // otherwise the row-major successor of the pixel currently on the port.
   always_comb begin
      base_d = base_q;
      col_d  = col_q + 4'd1;
      row_d  = row_q;
      if (state_q == ST_IDLE) begin
         base_d = pos_x(CurrState[1:0]);
         col_d  = '0;
         row_d  = '0;
      end else if (col_q == LAST_COL) begin
         col_d = '0;
         row_d = row_q + 3'd1;
      end
   end

   character_sprite_rom u_rom (
      .row_i (row_d),
      .col_i (col_d),
      .pix_o (pix)
   );

   // Control FSM with registered pixel outputs; the pixel shown during a
   // DRAW cycle was computed on the edge that entered that cycle.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         col_q       <= '0;
         row_q       <= '0;
         XOut        <= '0;
         YOut        <= '0;
         Color       <= BG_COLOR;
         Plot        <= 1'b0;
         Busy        <= 1'b0;
         DoneDrawing <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               Plot        <= 1'b0;
               DoneDrawing <= 1'b0;
               if (Start) begin
                  Busy <= 1'b1;
                  if (CurrState <= 4'd3) begin
                     state_q <= ST_DRAW;
                     base_q  <= base_d;
                     col_q   <= col_d;
                     row_q   <= row_d;
                     XOut    <= base_d + {4'd0, col_d};
                     YOut    <= BASE_Y + {4'd0, row_d};
                     Color   <= pix ? FG_COLOR : BG_COLOR;
                     Plot    <= 1'b1;
                  end else begin
                     // Invalid lane: finish immediately without plotting.
                     state_q     <= ST_DONE;
                     DoneDrawing <= 1'b1;
                  end
               end
            end
            ST_DRAW: begin
               if (col_q == LAST_COL && row_q == LAST_ROW) begin
                  state_q     <= ST_DONE;
                  Plot        <= 1'b0;
                  DoneDrawing <= 1'b1;
               end else begin
                  col_q <= col_d;
                  row_q <= row_d;
                  XOut  <= base_q + {4'd0, col_d};
                  YOut  <= BASE_Y + {4'd0, row_d};
                  Color <= pix ? FG_COLOR : BG_COLOR;
                  Plot  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               DoneDrawing <= 1'b0;
               Busy        <= 1'b0;
            end
            default: begin
               state_q     <= ST_IDLE;
               Plot        <= 1'b0;
               Busy        <= 1'b0;
               DoneDrawing <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_draw_character.sv
// Bench for draw_character: table of draw scenarios plus randomized draws,
// all checked against a pixel-level model of the sprite.
module tb_draw_character;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       Start;
   logic [3:0] CurrState;
   logic [7:0] XOut;
   logic [6:0] YOut;
   logic [2:0] Color;
   logic       Plot;
   logic       Busy;
   logic       DoneDrawing;

   int nvec  = 0;
   int nmiss = 0;

   draw_character dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Start       (Start),
      .CurrState   (CurrState),
      .XOut        (XOut),
      .YOut        (YOut),
      .Color       (Color),
      .Plot        (Plot),
      .Busy        (Busy),
      .DoneDrawing (DoneDrawing)
   );

   always #5 Clock = ~Clock;

   // Reference picture of the character, written the way it is drawn.
   string sprite_rows [5] = '{"000111000", "001111100", "111111111",
                              "001111100", "010000010"};

   function automatic int model_color(input int r, input int c);
      return (sprite_rows[r][c] == "1") ? 7 : 3;
   endfunction

   function automatic int model_base(input int cs);
      case (cs)
         0:       return 6;
         1:       return 24;
         2:       return 78;
         3:       return 132;
         default: return -1;
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nmiss++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Advance one clock; inputs change and outputs are read 1 time unit
   // after the rising edge.
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // One draw request. repulse_at: pixel index at which Start is raised
   // again with CurrState=cs2 (-1: never). reset_at: pixel index at which
   // Reset is raised (-1: never). scramble: randomize CurrState while busy.
   task automatic run_draw(input int cs, input int exp_base, input int repulse_at,
                           input int cs2, input int reset_at, input bit scramble);
      int dones;
      Start     = 1'b1;
      CurrState = 4'(cs);
      step();
      Start = 1'b0;
      if (exp_base < 0) begin
         chk("inv_plot", int'(Plot), 0);
         chk("inv_done", int'(DoneDrawing), 1);
         chk("inv_busy", int'(Busy), 1);
         step();
         chk("inv_done_after", int'(DoneDrawing), 0);
         chk("inv_busy_after", int'(Busy), 0);
         chk("inv_plot_after", int'(Plot), 0);
         return;
      end
      for (int i = 0; i < 45; i++) begin
         chk("plot", int'(Plot), 1);
         chk("x", int'(XOut), exp_base + i % 9);
         chk("y", int'(YOut), 102 + i / 9);
         chk("color", int'(Color), model_color(i / 9, i % 9));
         chk("busy", int'(Busy), 1);
         chk("done_early", int'(DoneDrawing), 0);
         if (i == reset_at) begin
            Reset = 1'b1;
            step();
            Reset = 1'b0;
            chk("rst_plot", int'(Plot), 0);
            chk("rst_busy", int'(Busy), 0);
            chk("rst_done", int'(DoneDrawing), 0);
            chk("rst_x", int'(XOut), 0);
            step();
            chk("rst_done2", int'(DoneDrawing), 0);
            chk("rst_plot2", int'(Plot), 0);
            return;
         end
         Start = (i == repulse_at);
         if (i == repulse_at) CurrState = 4'(cs2);
         else if (scramble) CurrState = 4'($urandom_range(0, 15));
         step();
         Start = 1'b0;
      end
      chk("end_plot", int'(Plot), 0);
      chk("end_done", int'(DoneDrawing), 1);
      chk("end_busy", int'(Busy), 1);
      step();
      chk("post_busy", int'(Busy), 0);
      dones = 0;
      for (int k = 0; k < 3; k++) begin
         if (DoneDrawing) dones++;
         if (Plot) dones += 100;
         step();
      end
      chk("no_extra_done_or_plot", dones, 0);
   endtask

   typedef struct {
      int cs;
      int exp_base;
      int repulse_at;
      int cs2;
      int reset_at;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{cs: 0,  exp_base: 6,   repulse_at: -1, cs2: 0, reset_at: -1};
      vecs[1] = '{cs: 3,  exp_base: 132, repulse_at: -1, cs2: 0, reset_at: -1};
      vecs[2] = '{cs: 1,  exp_base: 24,  repulse_at: 10, cs2: 2, reset_at: -1};
      vecs[3] = '{cs: 2,  exp_base: 78,  repulse_at: -1, cs2: 0, reset_at: 20};
      vecs[4] = '{cs: 2,  exp_base: 78,  repulse_at: -1, cs2: 0, reset_at: -1};
      vecs[5] = '{cs: 7,  exp_base: -1,  repulse_at: -1, cs2: 0, reset_at: -1};
      vecs[6] = '{cs: 4,  exp_base: -1,  repulse_at: -1, cs2: 0, reset_at: -1};
      vecs[7] = '{cs: 15, exp_base: -1,  repulse_at: -1, cs2: 0, reset_at: -1};

      Reset     = 1'b1;
      Start     = 1'b0;
      CurrState = 4'd0;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 10; i++) begin
         chk("idle_plot", int'(Plot), 0);
         chk("idle_busy", int'(Busy), 0);
         chk("idle_done", int'(DoneDrawing), 0);
         chk("idle_color", int'(Color), 3);
         step();
      end
      chk("idle_x", int'(XOut), 0);
      chk("idle_y", int'(YOut), 0);

      // Reset asserted together with Start wins.
      Reset     = 1'b1;
      Start     = 1'b1;
      CurrState = 4'd1;
      step();
      Reset = 1'b0;
      Start = 1'b0;
      chk("rst_vs_start_plot", int'(Plot), 0);
      chk("rst_vs_start_busy", int'(Busy), 0);
      step();
      chk("rst_vs_start_plot2", int'(Plot), 0);

      for (int v = 0; v < 8; v++) begin
         run_draw(vecs[v].cs, vecs[v].exp_base, vecs[v].repulse_at,
                  vecs[v].cs2, vecs[v].reset_at, 1'b0);
      end

      // Randomized draws with random lane, gaps, re-pulses and input noise.
      for (int n = 0; n < 24; n++) begin
         int cs;
         int rp;
         cs = int'($urandom_range(0, 7));
         rp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 44)) : -1;
         repeat ($urandom_range(0, 3)) step();
         run_draw(cs, model_base(cs), rp, int'($urandom_range(0, 7)), -1, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got %0d vectors expected completion", nvec);
      $fatal(1, "timeout");
   end

endmodule
